// File: rtl/bist_session_launcher.sv
// ----------------------------------------------------------------------------
// bist_session_launcher
//
// Initiator side of a BIST start/end handshake. A request from test-access
// logic launches a batch of back-to-back BIST sessions. Each session gets a
// one-cycle bist_start pulse, then waits for a rising edge on bist_end. A
// session whose bist_end edge does not arrive within TIMEOUT cycles ends the
// whole batch. The block reports one aggregate verdict per batch.
//
// Parameters
//    CNT_W       width of num_runs and fail_count
//    TMO_W       width of the per-session timeout counter
//    TIMEOUT     WAIT cycles allowed before a session is declared failed
//                (1 .. 2**TMO_W-1)
//    GAP_CYCLES  idle cycles with bist_start low between sessions (>= 1)
//
// Ports
//    clock        in   single clock, rising edge
//    reset        in   asynchronous, active-high
//    req          in   start a batch; only looked at while idle
//    num_runs     in   number of sessions; captured when req is accepted
//    bist_start   out  one-cycle pulse per session to the BIST controller
//    bist_end     in   completion level from the controller (rising edge counts)
//    pass_nfail   in   controller verdict, sampled in the completion cycle
//    busy         out  high from req acceptance until done
//    done         out  one-cycle pulse at batch end
//    all_pass     out  1 = no failed session and no timeout in the last batch
//    fail_count   out  failed sessions in the batch (a timeout counts as one)
//    timeout_err  out  sticky: a session timed out; cleared on the next batch
// ----------------------------------------------------------------------------
module bist_session_launcher #(
   parameter int CNT_W      = 8,
   parameter int TMO_W      = 16,
   parameter int TIMEOUT    = 5000,
   parameter int GAP_CYCLES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req,
   input  logic [CNT_W-1:0] num_runs,
   output logic             bist_start,
   input  logic             bist_end,
   input  logic             pass_nfail,
   output logic             busy,
   output logic             done,
   output logic             all_pass,
   output logic [CNT_W-1:0] fail_count,
   output logic             timeout_err
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      WAIT,
      GAP,
      FINISH
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] runs_left;
   logic [TMO_W-1:0] tmo_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             end_q;
   logic             completion;

   // Only a fresh 0->1 transition of bist_end finishes a session, so a level
   // left high by the previous session is never mistaken for completion.
   assign completion = bist_end & ~end_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         runs_left   <= '0;
         tmo_cnt     <= '0;
         gap_cnt     <= '0;
         end_q       <= 1'b0;
         bist_start  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         all_pass    <= 1'b1;
         fail_count  <= '0;
         timeout_err <= 1'b0;
      end else begin
         end_q      <= bist_end;
         bist_start <= 1'b0;
         done       <= 1'b0;

         case (state)
            IDLE: begin
               if (req) begin
                  runs_left   <= num_runs;
                  fail_count  <= '0;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
                  if (num_runs == '0) begin
                     state <= FINISH;
                  end else begin
                     // bist_start is registered, so it is raised on the
                     // transition into LAUNCH to be high during LAUNCH.
                     state      <= LAUNCH;
                     bist_start <= 1'b1;
                  end
               end
            end

            LAUNCH: begin
               tmo_cnt <= '0;
               state   <= WAIT;
            end

            WAIT: begin
               // Completion is checked first: it wins over a timeout that
               // would expire in the same cycle.
               if (completion) begin
                  if (!pass_nfail) begin
                     fail_count <= fail_count + 1'b1;
                  end
                  runs_left <= runs_left - 1'b1;
                  if (runs_left == CNT_W'(1)) begin
                     state <= FINISH;
                  end else begin
                     gap_cnt <= '0;
                     state   <= GAP;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  // The hung session counts as a failure and the rest of the
                  // batch is abandoned.
                  fail_count  <= fail_count + 1'b1;
                  timeout_err <= 1'b1;
                  state       <= FINISH;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end

            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state      <= LAUNCH;
                  bist_start <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end

            FINISH: begin
               done     <= 1'b1;
               busy     <= 1'b0;
               all_pass <= (fail_count == '0) && !timeout_err;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
